multi_input_gate_unit: RTL and testbench

//  Parametrised N-input logic gate with a registered output and selectable function
//  (AND/OR/NAND/NOR, plus XOR/XNOR when compiled in). Successor to the fixed 4-input NOR.

---
 rtl/multi_input_gate_unit.sv | 107 ++++++++++
 tb/tb_multi_input_gate_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/multi_input_gate_unit.sv
// N-input gate (AND/OR/NAND/NOR, XOR/XNOR when PARITY_MODES_EN is defined) with a
// registered output and a sweep FSM that walks all 2^N_IN patterns and counts the ones.
module multi_input_gate_unit #(
  parameter int N_IN = 4,
  parameter int HOLD = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      mode,
  input  logic [N_IN-1:0] in_vec,
  input  logic            in_valid,
  input  logic            sweep_start,
  output logic            out_y,
  output logic            out_valid,
  output logic            sweep_busy,
  output logic            sweep_done,
  output logic [N_IN-1:0] cur_pattern,
  output logic [N_IN:0]   ones_cnt
);

  localparam int            HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [N_IN:0] LAST_PAT  = {1'b0, {N_IN{1'b1}}};
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t          state, state_nx;
  logic [N_IN:0]   pat;
  logic [HW-1:0]   hold_cnt;
  logic [2:0]      mode_q;
  logic            sweep_eval, norm_eval, gate_y, hold_end;

  function automatic logic gate_f(input logic [2:0] m, input logic [N_IN-1:0] v);
    case (m)
      3'd0:    gate_f = &v;
      3'd1:    gate_f = |v;
      3'd2:    gate_f = ~&v;
      3'd3:    gate_f = ~|v;
`ifdef PARITY_MODES_EN
      3'd4:    gate_f = ^v;
      3'd5:    gate_f = ~^v;
`endif
      default: gate_f = 1'b0;
    endcase
  endfunction

  assign hold_end   = (hold_cnt == HOLD_LAST);
  // Sweep evaluates once per pattern, on its first hold cycle; a start in IDLE drops the operand.
  assign sweep_eval = (state == SWEEP) && (hold_cnt == '0);
  assign norm_eval  = (state == IDLE) && in_valid && !sweep_start;
  assign gate_y     = sweep_eval ? gate_f(mode_q, pat[N_IN-1:0]) : gate_f(mode, in_vec);

  assign sweep_busy  = (state == SWEEP);
  assign sweep_done  = (state == DONE);
  assign cur_pattern = sweep_busy ? pat[N_IN-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sweep_start) state_nx = SWEEP;
      SWEEP:   if ((pat == LAST_PAT) && hold_end) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_y     <= 1'b0;
      out_valid <= 1'b0;
      ones_cnt  <= '0;
      pat       <= '0;
      hold_cnt  <= '0;
      mode_q    <= '0;
    end else begin
      out_valid <= sweep_eval || norm_eval;
      if (sweep_eval || norm_eval) out_y <= gate_y;
      case (state)
        IDLE: if (sweep_start) begin
          mode_q   <= mode;
          ones_cnt <= '0;
          hold_cnt <= '0;
          pat      <= '0;
        end
        SWEEP: begin
          if (sweep_eval) ones_cnt <= ones_cnt + {{N_IN{1'b0}}, gate_y};
          if (hold_end) begin
            hold_cnt <= '0;
            pat      <= pat + (N_IN+1)'(1);
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          hold_cnt <= '0;
          pat      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_input_gate_unit.sv
// Randomized bench for multi_input_gate_unit: a 4-input/HOLD=1 and a 3-input/HOLD=3 instance
// checked against a truth-table model built from input popcounts.
module tb_multi_input_gate_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mode;
  logic [3:0] in_vec;
  logic       in_valid, ss1, ss2;

  logic       y1, ov1, sb1, sd1;
  logic [3:0] cp1;
  logic [4:0] oc1;
  logic       y2, ov2, sb2, sd2;
  logic [2:0] cp2;
  logic [3:0] oc2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multi_input_gate_unit #(.N_IN(4), .HOLD(1)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .in_vec(in_vec), .in_valid(in_valid),
    .sweep_start(ss1), .out_y(y1), .out_valid(ov1), .sweep_busy(sb1),
    .sweep_done(sd1), .cur_pattern(cp1), .ones_cnt(oc1)
  );

  multi_input_gate_unit #(.N_IN(3), .HOLD(3)) u_dut3 (
    .clk(clk), .rst(rst), .mode(mode), .in_vec(in_vec[2:0]), .in_valid(in_valid),
    .sweep_start(ss2), .out_y(y2), .out_valid(ov2), .sweep_busy(sb2),
    .sweep_done(sd2), .cur_pattern(cp2), .ones_cnt(oc2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Gate function from the count of set inputs.
  function automatic int ref_f(input int m, input int v, input int n);
    int ones;
    ones = $countones(v & ((1 << n) - 1));
    case (m)
      0: return (ones == n) ? 1 : 0;
      1: return (ones != 0) ? 1 : 0;
      2: return (ones != n) ? 1 : 0;
      3: return (ones == 0) ? 1 : 0;
`ifdef PARITY_MODES_EN
      4: return ones % 2;
      5: return 1 - (ones % 2);
`endif
      default: return 0;
    endcase
  endfunction

  task automatic sweep(input int w, input logic [2:0] m, input bit poke);
    int n, hold, tot, exp_ones;
    logic s_busy, s_ov, s_y, s_done;
    logic [31:0] s_cp, s_oc;
    bit exp_ov;
    n        = (w == 0) ? 4 : 3;
    hold     = (w == 0) ? 1 : 3;
    tot      = (1 << n) * hold;
    exp_ones = 0;
    for (int p = 0; p < (1 << n); p++) exp_ones += ref_f(m, p, n);
    @(negedge clk);
    mode = m; in_vec = 4'($urandom); in_valid = 1'b1;
    if (w == 0) ss1 = 1'b1; else ss2 = 1'b1;
    @(negedge clk);
    ss1 = 1'b0; ss2 = 1'b0; in_valid = 1'b0;
    mode = 3'($urandom);
    for (int idx = 0; idx <= tot + 1; idx++) begin
      if (idx > 0) @(negedge clk);
      if (w == 0) begin
        s_busy = sb1; s_ov = ov1; s_y = y1; s_done = sd1; s_cp = 32'(cp1); s_oc = 32'(oc1);
      end else begin
        s_busy = sb2; s_ov = ov2; s_y = y2; s_done = sd2; s_cp = 32'(cp2); s_oc = 32'(oc2);
      end
      if (idx <= tot) begin
        exp_ov = (idx >= 1) && ((idx - 1) % hold == 0);
        chk("sweep_busy", 32'(s_busy), (idx < tot) ? 1 : 0);
        chk("sweep_done", 32'(s_done), (idx == tot) ? 1 : 0);
        chk("cur_pattern", s_cp, (idx < tot) ? idx / hold : 0);
        chk("sweep_out_valid", 32'(s_ov), 32'(exp_ov));
        if (exp_ov) chk("sweep_out_y", 32'(s_y), ref_f(m, (idx - 1) / hold, n));
        if (idx == tot) chk("ones_cnt", s_oc, exp_ones);
      end else begin
        chk("done_clear", 32'(s_done), 0);
        chk("ones_hold", s_oc, exp_ones);
        chk("idle_out_valid", 32'(s_ov), 0);
      end
      if (poke && idx >= 1 && idx <= tot - 2) begin
        in_valid = 1'($urandom);
        in_vec   = 4'($urandom);
        if (w == 0) ss1 = (idx == 7 * hold); else ss2 = (idx == 7 * hold);
      end else begin
        in_valid = 1'b0; ss1 = 1'b0; ss2 = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic exp_y;
    int   dn;
    rst = 1'b1; mode = '0; in_vec = '0; in_valid = 1'b0; ss1 = 1'b0; ss2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_y", 32'(y1), 0);
    chk("rst_out_valid", 32'(ov1), 0);
    chk("rst_busy", 32'(sb1), 0);
    chk("rst_done", 32'(sd1), 0);
    chk("rst_cur_pattern", 32'(cp1), 0);
    chk("rst_ones_cnt", 32'(oc1), 0);
    rst = 1'b0;

    // Directed NOR checks.
    mode = 3'd3; in_vec = 4'b0000; in_valid = 1'b1;
    @(negedge clk);
    chk("nor0_y", 32'(y1), 1);
    chk("nor0_valid", 32'(ov1), 1);
    in_vec = 4'b0100;
    @(negedge clk);
    chk("nor4_y", 32'(y1), 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("nor_idle_valid", 32'(ov1), 0);
    chk("nor_idle_hold", 32'(y1), 0);

    // Random normal-mode operands, every mode code including reserved ones.
    exp_y = 1'b0;
    repeat (80) begin
      mode = 3'($urandom); in_vec = 4'($urandom); in_valid = 1'($urandom);
      @(negedge clk);
      if (in_valid) exp_y = 1'(ref_f(mode, in_vec, 4));
      chk("norm_valid", 32'(ov1), 32'(in_valid));
      chk("norm_y", 32'(y1), 32'(exp_y));
    end
    in_valid = 1'b0;

    sweep(0, 3'd3, 1'b0);
    sweep(0, 3'd0, 1'b0);
    sweep(0, 3'd1, 1'b0);
    sweep(0, 3'd2, 1'b0);
    sweep(0, 3'd4, 1'b0);
    sweep(0, 3'd5, 1'b0);
    sweep(0, 3'd6, 1'b0);
    sweep(0, 3'd3, 1'b1);
    sweep(1, 3'd1, 1'b0);
    sweep(1, 3'd0, 1'b1);

    // Reset while the sweep is on pattern 5.
    @(negedge clk);
    mode = 3'd3; ss1 = 1'b1;
    @(negedge clk);
    ss1 = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_pattern", 32'(cp1), 5);
    chk("pre_rst_ones", 32'(oc1), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(sb1), 0);
    chk("mid_rst_ones", 32'(oc1), 0);
    chk("mid_rst_valid", 32'(ov1), 0);
    chk("mid_rst_pattern", 32'(cp1), 0);
    dn = 0;
    repeat (24) begin
      @(negedge clk);
      dn += int'(sd1);
    end
    chk("mid_rst_no_done", 32'(dn), 0);
    chk("mid_rst_idle", 32'(sb1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
